// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer zoom copy sequencer.
//  - fb_state_e : sequencer state encoding (IDLE, CLEAR, RUN, DRAIN, DONE)
//  - ZOOM_1X/2X/4X : zoom_sel encodings (3 behaves as 1x)
//  - zoom_shift() : zoom_sel -> coordinate shift (0, 1 or 2)
//  - FB_IMG_W/FB_IMG_H/FB_AW/FB_DW : default image geometry and bus widths
package fb_pkg;

  localparam int FB_IMG_W = 160;
  localparam int FB_IMG_H = 120;
  localparam int FB_AW    = 19;
  localparam int FB_DW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_e;

  localparam logic [1:0] ZOOM_1X = 2'd0;
  localparam logic [1:0] ZOOM_2X = 2'd1;
  localparam logic [1:0] ZOOM_4X = 2'd2;

  // Map zoom selection to a shift amount; the unused code 3 falls back to 1x.
  function automatic logic [1:0] zoom_shift(input logic [1:0] zoom_sel);
    logic [1:0] s;
    case (zoom_sel)
      ZOOM_2X: s = 2'd1;
      ZOOM_4X: s = 2'd2;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fb_lat_pipe.sv
// fb_lat_pipe: LAT-stage shift register, async-reset to zero. Carries the
// {issue valid, destination address} pair so it lines up with ROM read data.
// Ports:
//  clk   in   1  clock
//  rst   in   1  asynchronous, active-high reset
//  din   in   W  value entering the first stage
//  dout  out  W  value leaving the last stage (LAT cycles later)
module fb_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [LAT];
  logic [W-1:0] stage_d [LAT];

  // Next value of every stage: input feeds stage 0, each stage feeds the next.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[LAT-1];

endmodule

// File: rtl/fb_zoom_sequencer.sv
// fb_zoom_sequencer: copies the source image ROM into the framebuffer RAM with
// a nearest-neighbour zoom of 1x, 2x or 4x. Destination pixels are walked in
// raster order; one ROM address is issued per cycle and the matching RAM write
// happens ROM_LAT cycles later.
// Optional feature macro: FB_CLEAR_EN -- when defined, each accepted start first
// zero-fills framebuffer addresses 0..FB_WORDS-1 (CLEAR state) before copying.
// Ports:
//  clk        in   1   pixel clock
//  reset      in   1   asynchronous, active-high
//  start      in   1   copy request, accepted only in IDLE
//  zoom_sel   in   2   0=1x 1=2x 2=4x 3=1x, sampled on the accepted start
//  busy       out  1   copy in progress
//  done       out  1   one-cycle pulse after the last RAM write
//  rom_addr   out  AW  source pixel address
//  rom_data   in   DW  ROM data, valid ROM_LAT cycles after rom_addr
//  ram_wraddr out  AW  framebuffer write address
//  ram_data   out  DW  framebuffer write data
//  ram_wren   out  1   framebuffer write enable
module fb_zoom_sequencer
  import fb_pkg::*;
#(
  parameter int IMG_W   = FB_IMG_W,
  parameter int IMG_H   = FB_IMG_H,
  parameter int AW      = FB_AW,
  parameter int DW      = FB_DW,
  parameter int ROM_LAT = 1
`ifdef FB_CLEAR_EN
  ,
  parameter int FB_WORDS = 307200
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    zoom_sel,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] ram_wraddr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren
);

  localparam logic [AW-1:0] ZERO_A     = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A      = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IMG_W_C    = AW'(IMG_W);
  localparam logic [AW-1:0] IMG_H_C    = AW'(IMG_H);
  localparam logic [1:0]    DRAIN_LAST = 2'(ROM_LAT - 1);
`ifdef FB_CLEAR_EN
  localparam logic [AW-1:0] CLR_LAST   = AW'(FB_WORDS - 1);
`endif

  fb_state_e     state_q, state_d;
  logic [1:0]    shift_q, shift_d;
  logic [AW-1:0] dx_q, dx_d;
  logic [AW-1:0] dy_q, dy_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          issue_q, issue_d;
  logic [1:0]    drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef FB_CLEAR_EN
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clr_wren_q, clr_wren_d;
`endif

  logic [AW-1:0] dst_w_s, dst_h_s;
  logic [AW-1:0] nx_s, ny_s, next_rom_s;
  logic          last_x_s, last_y_s;
  logic [AW:0]   pipe_out_s;
  logic          wr_valid_s;
  logic [AW-1:0] wr_addr_s;

  // Destination geometry and the coordinates/source address of the next pixel.
  // The source address uses only shifts plus a constant multiply by IMG_W.
  always_comb begin
    dst_w_s    = IMG_W_C << shift_q;
    dst_h_s    = IMG_H_C << shift_q;
    last_x_s   = (dx_q == (dst_w_s - ONE_A));
    last_y_s   = (dy_q == (dst_h_s - ONE_A));
    if (last_x_s) begin
      nx_s = ZERO_A;
      ny_s = dy_q + ONE_A;
    end else begin
      nx_s = dx_q + ONE_A;
      ny_s = dy_q;
    end
    next_rom_s = ((ny_s >> shift_q) * IMG_W_C) + (nx_s >> shift_q);
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    dst_d      = dst_q;
    rom_addr_d = rom_addr_q;
    issue_d    = 1'b0;
    drain_d    = drain_q;
`ifdef FB_CLEAR_EN
    clr_addr_d = clr_addr_q;
    clr_wren_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = zoom_shift(zoom_sel);
`ifdef FB_CLEAR_EN
          state_d    = ST_CLEAR;
          clr_addr_d = ZERO_A;
          clr_wren_d = 1'b1;
`else
          // First pixel (0,0) is presented on rom_addr in the very next cycle.
          state_d    = ST_RUN;
          dx_d       = ZERO_A;
          dy_d       = ZERO_A;
          dst_d      = ZERO_A;
          rom_addr_d = ZERO_A;
          issue_d    = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        if (clr_addr_q == CLR_LAST) begin
          state_d    = ST_RUN;
          dx_d       = ZERO_A;
          dy_d       = ZERO_A;
          dst_d      = ZERO_A;
          rom_addr_d = ZERO_A;
          issue_d    = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ONE_A;
          clr_wren_d = 1'b1;
        end
      end
`endif
      ST_RUN: begin
        if (last_x_s && last_y_s) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else begin
          dx_d       = nx_s;
          dy_d       = ny_s;
          dst_d      = dst_q + ONE_A;
          rom_addr_d = next_rom_s;
          issue_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wait for the last issued pixel to leave the latency pipe.
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 2'd0;
      dx_q       <= ZERO_A;
      dy_q       <= ZERO_A;
      dst_q      <= ZERO_A;
      rom_addr_q <= ZERO_A;
      issue_q    <= 1'b0;
      drain_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      dst_q      <= dst_d;
      rom_addr_q <= rom_addr_d;
      issue_q    <= issue_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef FB_CLEAR_EN
  // Clear-pass write address/enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr_q <= ZERO_A;
      clr_wren_q <= 1'b0;
    end else begin
      clr_addr_q <= clr_addr_d;
      clr_wren_q <= clr_wren_d;
    end
  end
`endif

  fb_lat_pipe #(
    .LAT (ROM_LAT),
    .W   (AW + 1)
  ) u_lat_pipe (
    .clk  (clk),
    .rst  (reset),
    .din  ({issue_q, dst_q}),
    .dout (pipe_out_s)
  );

  assign wr_valid_s = pipe_out_s[AW];
  assign wr_addr_s  = pipe_out_s[AW-1:0];

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  // Data is forced to zero outside image writes so reset and clear show 0.
  assign ram_data = wr_valid_s ? rom_data : {DW{1'b0}};
`ifdef FB_CLEAR_EN
  // Clear writes and image writes never overlap: the first image write lands
  // ROM_LAT cycles after the clear pass ends.
  assign ram_wren   = wr_valid_s | clr_wren_q;
  assign ram_wraddr = clr_wren_q ? clr_addr_q : wr_addr_s;
`else
  assign ram_wren   = wr_valid_s;
  assign ram_wraddr = wr_addr_s;
`endif

endmodule

// File: tb/tb_fb_zoom_sequencer.sv
// Bench for fb_zoom_sequencer using a reduced 8x6 source image so every zoom
// finishes quickly. The ROM model returns rom[a] = (7*a + 3) mod 256, which is
// distinct for every source address used here.
module tb_fb_zoom_sequencer;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int AW    = 19;
  localparam int DW    = 8;
`ifdef FB_CLEAR_EN
  localparam int ROM_LAT  = 3;
  localparam int FB_WORDS = 800;
`else
  localparam int ROM_LAT  = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    zoom_sel = 2'd0;
  logic          busy, done, ram_wren;
  logic [AW-1:0] rom_addr, ram_wraddr;
  logic [DW-1:0] rom_data, ram_data;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] fb [1024];

  always #5 clk = ~clk;

  fb_zoom_sequencer #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .AW      (AW),
    .DW      (DW),
    .ROM_LAT (ROM_LAT)
`ifdef FB_CLEAR_EN
    ,
    .FB_WORDS (FB_WORDS)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .zoom_sel   (zoom_sel),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_wraddr (ram_wraddr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren)
  );

  function automatic logic [7:0] rom_val(input int a);
    return 8'((a * 7) + 3);
  endfunction

  function automatic logic [7:0] exp_pix(input int n, input int s);
    int dw, x, y;
    dw = IMG_W << s;
    x  = n % dw;
    y  = n / dw;
    return rom_val(((y >> s) * IMG_W) + (x >> s));
  endfunction

  // ROM model with ROM_LAT cycles of read latency.
  logic [7:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_val(int'(rom_addr));
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // Caller is at a negedge; start is raised here. Returns at the negedge of
  // the IDLE cycle following done.
  task automatic do_copy(input logic [1:0] zs, input bit pulse_busy, input bit pulse_done);
    int s, nexp, cnt;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    s    = (zs == 2'd1) ? 1 : ((zs == 2'd2) ? 2 : 0);
    nexp = (IMG_W << s) * (IMG_H << s);
    zoom_sel = zs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_busy zoom=%0d busy=%b done=%b want busy=1 done=0", zs, busy, done);
    end
`ifdef FB_CLEAR_EN
    for (int k = 0; k < FB_WORDS; k++) begin
      total++;
      if ({busy, ram_wren, ram_wraddr, ram_data} !== {1'b1, 1'b1, AW'(k), 8'h00}) begin
        bad++;
        $display("FAIL clear_write k=%0d busy=%b wren=%b addr=%0d data=%0h want 1 1 %0d 0",
                 k, busy, ram_wren, ram_wraddr, ram_data, k);
      end
      @(negedge clk);
    end
`endif
    cnt = 0;
    while (ram_wren !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    total++;
    if (cnt != ROM_LAT) begin
      bad++;
      $display("FAIL first_write_latency zoom=%0d got=%0d want=%0d", zs, cnt, ROM_LAT);
    end
    for (int n = 0; n < nexp; n++) begin
      ea = AW'(n);
      ed = exp_pix(n, s);
      total++;
      if ({busy, done, ram_wren, ram_wraddr, ram_data} !== {1'b1, 1'b0, 1'b1, ea, ed}) begin
        bad++;
        $display("FAIL image_write zoom=%0d n=%0d busy=%b done=%b wren=%b addr=%0d data=%0h want 1 0 1 %0d %0h",
                 zs, n, busy, done, ram_wren, ram_wraddr, ram_data, ea, ed);
      end
      if (ram_wren === 1'b1 && ram_wraddr < 19'd1024) fb[ram_wraddr[9:0]] = ram_data;
      if (pulse_busy && (n % 100) == 50) begin
        start = 1'b1;
        zoom_sel = ~zs;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if ({busy, done, ram_wren} !== 3'b010) begin
      bad++;
      $display("FAIL done_pulse zoom=%0d busy=%b done=%b wren=%b want 0 1 0", zs, busy, done, ram_wren);
    end
    start = pulse_done;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, done, ram_wren} !== 3'b000) begin
      bad++;
      $display("FAIL after_done zoom=%0d busy=%b done=%b wren=%b want 0 0 0", zs, busy, done, ram_wren);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    total++;
    if ({busy, done, ram_wren, ram_wraddr, ram_data, rom_addr} !== {(3 + AW + DW + AW){1'b0}}) begin
      bad++;
      $display("FAIL reset_outputs busy=%b done=%b wren=%b wraddr=%0d data=%0h rom_addr=%0d want all 0",
               busy, done, ram_wren, ram_wraddr, ram_data, rom_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, ram_wren} !== 3'b000) begin
        bad++;
        $display("FAIL idle_quiet cycle=%0d busy=%b done=%b wren=%b want 0 0 0", i, busy, done, ram_wren);
      end
    end
  endtask

  task automatic test_zoom2x();
    do_copy(2'd1, 1'b0, 1'b0);
    total++;
    if ({fb[0], fb[1], fb[16], fb[17], fb[2]} !== {8'd3, 8'd3, 8'd3, 8'd3, 8'd10}) begin
      bad++;
      $display("FAIL zoom2x_spots got %0d %0d %0d %0d %0d want 3 3 3 3 10",
               fb[0], fb[1], fb[16], fb[17], fb[2]);
    end
  endtask

  task automatic test_zoom4x_start_ignored();
    do_copy(2'd2, 1'b1, 1'b0);
    total++;
    if ({fb[3], fb[4], fb[767]} !== {8'd3, 8'd10, 8'd76}) begin
      bad++;
      $display("FAIL zoom4x_spots got %0d %0d %0d want 3 10 76", fb[3], fb[4], fb[767]);
    end
  endtask

  task automatic test_zoom1x();
    do_copy(2'd0, 1'b0, 1'b0);
    total++;
    if ({fb[13], fb[47]} !== {8'd94, 8'd76}) begin
      bad++;
      $display("FAIL zoom1x_identity got %0d %0d want 94 76", fb[13], fb[47]);
    end
  endtask

  task automatic test_back_to_back();
    // zoom 3 acts as 1x; start during DONE is ignored, start right after is taken.
    do_copy(2'd3, 1'b0, 1'b1);
    do_copy(2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int n, cnt;
    zoom_sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    cnt = 0;
    while (n < 50 && cnt < 2000) begin
      if (ram_wren === 1'b1) n++;
      @(negedge clk);
      cnt++;
    end
    total++;
    if (ram_wren !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_midcopy wren=%b busy=%b writes=%0d want wren=1 busy=1", ram_wren, busy, n);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, ram_wren, ram_wraddr} !== {(3 + AW){1'b0}}) begin
      bad++;
      $display("FAIL abort_async busy=%b done=%b wren=%b wraddr=%0d want all 0", busy, done, ram_wren, ram_wraddr);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, ram_wren} !== 3'b000) begin
        bad++;
        $display("FAIL abort_no_done cycle=%0d busy=%b done=%b wren=%b want 0 0 0", i, busy, done, ram_wren);
      end
    end
    do_copy(2'd1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_zoom2x();
    test_zoom4x_start_ignored();
    test_zoom1x();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
